// File: rtl/switch_xbar_rr_if.sv
// Port bundle of the round-robin crossbar: per-input source handshake and per-output sink handshake.
// The switch side uses the slave modport; the source/sink side uses master.
interface switch_xbar_rr_if #(
  parameter int AW = 2,
  parameter int DW = 4
);
  localparam int NP = 2**AW;

  logic [NP-1:0]    validtx;
  logic [NP*AW-1:0] adr_i;
  logic [NP*DW-1:0] dat_i;
  logic [NP-1:0]    acktx;
  logic [NP-1:0]    validrx;
  logic [NP*DW-1:0] dat_o;
  logic [NP*AW-1:0] src_o;
  logic [NP-1:0]    ackrx;

  modport master (
    output validtx, adr_i, dat_i, ackrx,
    input  acktx, validrx, dat_o, src_o
  );

  modport slave (
    input  validtx, adr_i, dat_i, ackrx,
    output acktx, validrx, dat_o, src_o
  );
endinterface

// File: rtl/switch_xbar_rr.sv
// N-port crossbar: one FIFO per input, one round-robin arbiter and one holding register per output.
// Each output reports the index of the input that sourced the word it holds.
module switch_xbar_rr #(
  parameter int AW    = 2,
  parameter int DW    = 4,
  parameter int DEPTH = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  switch_xbar_rr_if.slave bus
);
  localparam int NP = 2**AW;
  localparam int FD = 2**DEPTH;
  localparam int EW = AW + DW;

  logic [NP-1:0]    empty, full, push, pop;
  logic [AW-1:0]    head_adr [NP];
  logic [DW-1:0]    head_dat [NP];

  logic [NP-1:0]    slot_free, gnt_vld;
  logic [AW-1:0]    gnt_idx [NP];
  logic [AW-1:0]    cand;
  logic [AW-1:0]    rr [NP];

  logic [NP-1:0]    validrx_q;
  logic [NP*DW-1:0] dat_q;
  logic [NP*AW-1:0] src_q;

  // Per-input FIFO; the extra pointer MSB distinguishes full from empty.
  for (genvar p = 0; p < NP; p++) begin : g_fifo
    logic [EW-1:0]  mem [FD];
    logic [DEPTH:0] wr_ptr, rd_ptr;
    logic [EW-1:0]  head;

    assign empty[p] = (wr_ptr == rd_ptr);
    assign full[p]  = (wr_ptr[DEPTH] != rd_ptr[DEPTH]) &&
                      (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]);
    assign push[p]  = bus.validtx[p] & ~full[p];
    assign head     = mem[rd_ptr[DEPTH-1:0]];
    assign head_adr[p] = head[EW-1:DW];
    assign head_dat[p] = head[DW-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[p]) wr_ptr <= wr_ptr + (DEPTH+1)'(1);
        if (pop[p])  rd_ptr <= rd_ptr + (DEPTH+1)'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[p]) mem[wr_ptr[DEPTH-1:0]] <= {bus.adr_i[p*AW +: AW], bus.dat_i[p*DW +: DW]};
    end
  end

  // First requester at or after rr[q]; a head requests only one output, so each input pops at most once.
  always_comb begin
    pop  = '0;
    cand = '0;
    for (int q = 0; q < NP; q++) begin
      gnt_vld[q]   = 1'b0;
      gnt_idx[q]   = '0;
      slot_free[q] = ~validrx_q[q] | bus.ackrx[q];
      for (int i = 0; i < NP; i++) begin
        cand = rr[q] + AW'(i);
        if (!gnt_vld[q] && !empty[cand] && head_adr[cand] == AW'(q)) begin
          gnt_vld[q] = 1'b1;
          gnt_idx[q] = cand;
        end
      end
      if (gnt_vld[q] && slot_free[q]) pop[gnt_idx[q]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      validrx_q <= '0;
      dat_q     <= '0;
      src_q     <= '0;
      for (int q = 0; q < NP; q++) rr[q] <= '0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        if (slot_free[q]) begin
          if (gnt_vld[q]) begin
            validrx_q[q]         <= 1'b1;
            dat_q[q*DW +: DW]    <= head_dat[gnt_idx[q]];
            src_q[q*AW +: AW]    <= gnt_idx[q];
            rr[q]                <= gnt_idx[q] + AW'(1);
          end else begin
            validrx_q[q]         <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.acktx   = ~full;
  assign bus.validrx = validrx_q;
  assign bus.dat_o   = dat_q;
  assign bus.src_o   = src_q;
endmodule

// File: tb/tb_switch_xbar_rr.sv
// Directed bench for switch_xbar_rr (AW=2, DW=4, DEPTH=2) with hand-computed expectations.
module tb_switch_xbar_rr;
  localparam int AW = 2, DW = 4, DEPTH = 2, NP = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  switch_xbar_rr_if #(.AW(AW), .DW(DW)) bus ();
  switch_xbar_rr #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.validtx = '0;
    bus.adr_i   = '0;
    bus.dat_i   = '0;
    bus.ackrx   = '0;
  endtask

  task automatic drive(input int p, input int adr, input int dat);
    bus.validtx[p]          = 1'b1;
    bus.adr_i[p*AW +: AW]   = AW'(adr);
    bus.dat_i[p*DW +: DW]   = DW'(dat);
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    #3;
    vecs++; if (bus.validrx !== 4'b0000) begin errs++; $display("FAIL reset_validrx got %b want 0000", bus.validrx); end
    vecs++; if (bus.dat_o !== 16'h0000) begin errs++; $display("FAIL reset_dat got %h want 0000", bus.dat_o); end
    vecs++; if (bus.src_o !== 8'h00) begin errs++; $display("FAIL reset_src got %h want 00", bus.src_o); end
    vecs++; if (bus.acktx !== 4'b1111) begin errs++; $display("FAIL reset_acktx got %b want 1111", bus.acktx); end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    drive(0, 1, 5);
    drive(2, 3, 6);
    tick();
    bus.validtx[0] = 1'b0;
    drive(2, 3, 7);
    tick();
    vecs++; if (bus.validrx !== 4'b1010) begin errs++; $display("FAIL pre_reset_traffic got %b want 1010", bus.validrx); end
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    vecs++; if (bus.validrx !== 4'b0000) begin errs++; $display("FAIL midreset_validrx got %b want 0000", bus.validrx); end
    vecs++; if (bus.dat_o !== 16'h0000) begin errs++; $display("FAIL midreset_dat got %h want 0000", bus.dat_o); end
    vecs++; if (bus.src_o !== 8'h00) begin errs++; $display("FAIL midreset_src got %h want 00", bus.src_o); end
    vecs++; if (bus.acktx !== 4'b1111) begin errs++; $display("FAIL midreset_acktx got %b want 1111", bus.acktx); end
    idle();
    #2;
    rst_i = 1'b1;
    tick(); tick(); tick();
    vecs++; if (bus.validrx !== 4'b0000) begin errs++; $display("FAIL post_reset_stale got %b want 0000", bus.validrx); end
    vecs++; if (bus.acktx !== 4'b1111) begin errs++; $display("FAIL post_reset_acktx got %b want 1111", bus.acktx); end
  endtask

  task automatic test_single_path();
    idle();
    drive(1, 2, 4'hA);
    vecs++; if (bus.acktx[1] !== 1'b1) begin errs++; $display("FAIL single_acktx got %b want 1", bus.acktx[1]); end
    tick();
    idle();
    vecs++; if (bus.validrx[2] !== 1'b0) begin errs++; $display("FAIL single_early got %b want 0", bus.validrx[2]); end
    tick();
    vecs++; if (bus.validrx !== 4'b0100) begin errs++; $display("FAIL single_valid got %b want 0100", bus.validrx); end
    vecs++; if (bus.dat_o[2*DW +: DW] !== 4'hA) begin errs++; $display("FAIL single_dat got %h want a", bus.dat_o[2*DW +: DW]); end
    vecs++; if (bus.src_o[2*AW +: AW] !== 2'd1) begin errs++; $display("FAIL single_src got %0d want 1", bus.src_o[2*AW +: AW]); end
    tick(); tick();
    vecs++; if (bus.validrx[2] !== 1'b1 || bus.dat_o[2*DW +: DW] !== 4'hA) begin errs++; $display("FAIL single_hold got %b/%h want 1/a", bus.validrx[2], bus.dat_o[2*DW +: DW]); end
    bus.ackrx[2] = 1'b1;
    tick();
    vecs++; if (bus.validrx[2] !== 1'b0) begin errs++; $display("FAIL single_consume got %b want 0", bus.validrx[2]); end
    vecs++; if (bus.dat_o[2*DW +: DW] !== 4'hA) begin errs++; $display("FAIL single_dat_kept got %h want a", bus.dat_o[2*DW +: DW]); end
    idle();
  endtask

  task automatic test_round_robin();
    idle();
    for (int p = 0; p < NP; p++) drive(p, 0, p);
    bus.ackrx[0] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      vecs++; if (bus.validrx[0] !== 1'b1) begin errs++; $display("FAIL rr_valid step %0d got %b want 1", k, bus.validrx[0]); end
      vecs++; if (bus.src_o[AW-1:0] !== AW'(k % 4)) begin errs++; $display("FAIL rr_src step %0d got %0d want %0d", k, bus.src_o[AW-1:0], k % 4); end
      vecs++; if (bus.dat_o[DW-1:0] !== DW'(k % 4)) begin errs++; $display("FAIL rr_dat step %0d got %0d want %0d", k, bus.dat_o[DW-1:0], k % 4); end
      tick();
    end
    idle();
    bus.ackrx[0] = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    vecs++; if (bus.validrx[0] !== 1'b0) begin errs++; $display("FAIL rr_drained got %b want 0", bus.validrx[0]); end
    vecs++; if (bus.acktx !== 4'b1111) begin errs++; $display("FAIL rr_acktx got %b want 1111", bus.acktx); end
    idle();
  endtask

  task automatic test_full_stall();
    logic acc;
    idle();
    for (int w = 1; w <= 5; w++) begin
      drive(3, 1, w);
      vecs++; if (bus.acktx[3] !== 1'b1) begin errs++; $display("FAIL full_accept word %0d got %b want 1", w, bus.acktx[3]); end
      tick();
    end
    drive(3, 1, 6);
    vecs++; if (bus.acktx[3] !== 1'b0) begin errs++; $display("FAIL full_flag got %b want 0", bus.acktx[3]); end
    vecs++; if (bus.validrx[1] !== 1'b1 || bus.dat_o[DW +: DW] !== 4'd1) begin errs++; $display("FAIL full_out got %b/%0d want 1/1", bus.validrx[1], bus.dat_o[DW +: DW]); end
    tick(); tick();
    vecs++; if (bus.acktx[3] !== 1'b0) begin errs++; $display("FAIL full_stall got %b want 0", bus.acktx[3]); end
    vecs++; if (bus.dat_o[DW +: DW] !== 4'd1) begin errs++; $display("FAIL full_hold got %0d want 1", bus.dat_o[DW +: DW]); end
    bus.ackrx[1] = 1'b1;
    for (int w = 2; w <= 6; w++) begin
      acc = bus.validtx[3] & bus.acktx[3];
      tick();
      if (acc) bus.validtx[3] = 1'b0;
      vecs++; if (bus.validrx[1] !== 1'b1) begin errs++; $display("FAIL drain_valid word %0d got %b want 1", w, bus.validrx[1]); end
      vecs++; if (bus.dat_o[DW +: DW] !== DW'(w)) begin errs++; $display("FAIL drain_dat got %0d want %0d", bus.dat_o[DW +: DW], w); end
      vecs++; if (bus.src_o[AW +: AW] !== 2'd3) begin errs++; $display("FAIL drain_src got %0d want 3", bus.src_o[AW +: AW]); end
    end
    tick();
    vecs++; if (bus.validrx[1] !== 1'b0) begin errs++; $display("FAIL drain_end got %b want 0", bus.validrx[1]); end
    idle();
  endtask

  task automatic test_parallel();
    idle();
    for (int p = 0; p < NP; p++) drive(p, 3 - p, 8 + p);
    tick();
    idle();
    vecs++; if (bus.validrx !== 4'b0000) begin errs++; $display("FAIL par_early got %b want 0000", bus.validrx); end
    tick();
    vecs++; if (bus.validrx !== 4'b1111) begin errs++; $display("FAIL par_valid got %b want 1111", bus.validrx); end
    for (int q = 0; q < NP; q++) begin
      vecs++; if (bus.src_o[q*AW +: AW] !== AW'(3 - q)) begin errs++; $display("FAIL par_src out %0d got %0d want %0d", q, bus.src_o[q*AW +: AW], 3 - q); end
      vecs++; if (bus.dat_o[q*DW +: DW] !== DW'(11 - q)) begin errs++; $display("FAIL par_dat out %0d got %0d want %0d", q, bus.dat_o[q*DW +: DW], 11 - q); end
    end
    bus.ackrx = 4'b1111;
    tick();
    vecs++; if (bus.validrx !== 4'b0000) begin errs++; $display("FAIL par_consume got %b want 0000", bus.validrx); end
    idle();
  endtask

  task automatic test_head_of_line();
    idle();
    drive(3, 1, 7);
    tick();
    idle();
    tick();
    drive(0, 1, 1);
    tick();
    drive(0, 2, 2);
    drive(1, 2, 3);
    tick();
    idle();
    tick();
    vecs++; if (bus.validrx[1] !== 1'b1 || bus.dat_o[DW +: DW] !== 4'd7 || bus.src_o[AW +: AW] !== 2'd3) begin errs++; $display("FAIL hol_out1 got %b/%0d/%0d want 1/7/3", bus.validrx[1], bus.dat_o[DW +: DW], bus.src_o[AW +: AW]); end
    vecs++; if (bus.validrx[2] !== 1'b1 || bus.dat_o[2*DW +: DW] !== 4'd3 || bus.src_o[2*AW +: AW] !== 2'd1) begin errs++; $display("FAIL hol_out2 got %b/%0d/%0d want 1/3/1", bus.validrx[2], bus.dat_o[2*DW +: DW], bus.src_o[2*AW +: AW]); end
    bus.ackrx[2] = 1'b1;
    tick();
    bus.ackrx[2] = 1'b0;
    vecs++; if (bus.validrx[2] !== 1'b0) begin errs++; $display("FAIL hol_blocked got %b want 0", bus.validrx[2]); end
    bus.ackrx[1] = 1'b1;
    tick();
    bus.ackrx[1] = 1'b0;
    vecs++; if (bus.validrx[1] !== 1'b1 || bus.dat_o[DW +: DW] !== 4'd1 || bus.src_o[AW +: AW] !== 2'd0) begin errs++; $display("FAIL hol_release1 got %b/%0d/%0d want 1/1/0", bus.validrx[1], bus.dat_o[DW +: DW], bus.src_o[AW +: AW]); end
    tick();
    vecs++; if (bus.validrx[2] !== 1'b1 || bus.dat_o[2*DW +: DW] !== 4'd2 || bus.src_o[2*AW +: AW] !== 2'd0) begin errs++; $display("FAIL hol_release2 got %b/%0d/%0d want 1/2/0", bus.validrx[2], bus.dat_o[2*DW +: DW], bus.src_o[2*AW +: AW]); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_path();
    test_round_robin();
    test_full_stall();
    test_parallel();
    test_head_of_line();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/switch_xbar_rr.md
Name: switch_xbar_rr

Overview:
Parametrised N-port crossbar switch; next generation of the fixed 4-port switch. Each input port has its own FIFO. Each output port has a round-robin arbiter and a one-word holding register. Outputs report which input port sourced the word they hold. Sits between the source devices and the sink devices in the switch top level, clocked by the switch clock.

Parameters:
AW, 2, port-address width; port count NP = 2**AW (localparam); legal AW is 1..4.
DW, 4, data width in bits.
DEPTH, 2, log2 of per-input FIFO depth; each FIFO holds 2**DEPTH words.

Ports:
clk_i  input  1  switch clock; all state on rising edge.
rst_i  input  1  reset, asynchronous, active-low; named as the codebase does.
validtx  input  NP  per-input source valid; bit p = input p.
adr_i  input  NP*AW  per-input destination port; slice [p*AW +: AW].
dat_i  input  NP*DW  per-input data; slice [p*DW +: DW].
acktx  output  NP  per-input accept, combinational = FIFO p not full.
validrx  output  NP  per-output word-held flag; bit q = output q.
dat_o  output  NP*DW  per-output held data; slice [q*DW +: DW].
src_o  output  NP*AW  per-output source input index of the held word.
ackrx  input  NP  per-output sink consume.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - all FIFOs empty, so acktx = all ones;
  - validrx=0, dat_o=0, src_o=0;
  - every round-robin pointer = 0.
  - Reset mid-operation discards all buffered words; nothing is flushed.
- Input handshake:
  - A word {adr_i, dat_i} is written to FIFO p on an edge where validtx[p] & acktx[p].
  - validtx while full is a stall, not a drop; the source holds its word.
  - Full and empty use a wrap-around pointer with an extra MSB.
  - Push on a full FIFO is impossible. A simultaneous push and pop on a full FIFO is not allowed: acktx is based on the current full flag only.
- Request: input p requests output q when FIFO p is non-empty and head address == q. Each head requests exactly one output.
- Output slot q is free when validrx[q]==0 or ackrx[q]==1 in this cycle. ackrx while validrx==0 is ignored.
- Arbitration, per output q, every cycle the slot is free:
  - Among requesting inputs, grant the first one at or after pointer rr[q], searching upward modulo NP.
  - On grant g: FIFO g pops; dat_o[q] <= head data; src_o[q] <= g; validrx[q] <= 1; rr[q] <= (g+1) mod NP.
  - No grant and ackrx consumed the word: validrx[q] <= 0. dat_o and src_o keep their last values.
  - No grant and the slot is not free: hold everything.
- Distinct outputs arbitrate independently; different inputs can reach different outputs in the same cycle. Each input pops at most one word per cycle.
- Latency:
  - A word accepted at edge k into an empty FIFO with a free, uncontended output shows validrx=1 after edge k+1.
  - Full throughput is 1 word/cycle per output when the sink holds ackrx=1.
- Ordering: per input, words leave in arrival order (head-of-line blocking is accepted). No ordering guarantee across inputs.
- Back-to-back: consume and reload in the same edge is allowed, so validrx stays high with no bubble.
- Implementation scope: a per-input FIFO submodule, or a generate block of FIFOs, is allowed.

Test Plan:
- Reset: drive traffic, pull rst_i low mid-packet between edges -> outputs clear immediately to validrx=0, dat_o=0, src_o=0, acktx=4'b1111; no stale word appears after release.
- Single path (AW=2, DW=4): input 1 sends adr=2, dat=4'hA at edge k; ackrx[2] held 0 -> validrx[2]=1 after edge k+1, dat_o slice2=4'hA, src_o slice2=1; it stays held until ackrx[2]=1, then validrx[2]=0 on the next edge.
- Round-robin contention: all 4 inputs send dat=p to output 0; ackrx[0]=1 continuously -> output 0 delivers src 0,1,2,3,0... with no bubbles; each input is served once per 4 cycles.
- Full/stall: DEPTH=2; input 3 sends 6 words to output 1 with ackrx[1]=0 -> 1 word enters the output register and 4 fill the FIFO; acktx[3]=0 after the 5th accept; the 6th word stalls. Releasing ackrx=1 then drains all 6 in order.
- Parallel paths: inputs 0,1,2,3 target outputs 3,2,1,0 simultaneously -> all 4 validrx rise on the same edge with correct src_o; no cross-blocking.
- Head-of-line: input 0 sends to blocked output 1 (ackrx[1]=0), then to output 2 -> the output-2 word waits until output 1's word is consumed; input 1 to output 2 is unaffected.
